wave_synth: RTL

Tone generator stage directly downstream of the keypad input driver. Consumes the per-note period `divider`, waveform `mode` and key-held `strobe`, and runs an 8-bit phase oscillator. Produces an 8-bit registered audio `sample` plus a single-bit PWM `pwm_out` that drives the speaker pin through an external RC filter.

---
 rtl/wave_synth.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wave_synth.sv
// rtl/wave_synth.sv - 8-bit phase oscillator tone generator with registered sample and PWM output
// Optional volume envelope enabled by defining ENVELOPE_EN.
module wave_synth
`ifdef ENVELOPE_EN
#(
    parameter int ENV_CYCLES = 39062
)
`endif
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [17:0] divider,
    input  logic [1:0]  mode,
    input  logic        strobe,
    output logic [7:0]  sample,
    output logic        pwm_out,
    output logic        active
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      r_state;
    logic [9:0]  r_div_lat;
    logic [9:0]  r_tick;
    logic [7:0]  r_phase;
    logic [7:0]  r_pwm_cnt;

    logic [9:0]  w_step_len;
    logic        w_step_end;
    logic        w_gate;
    logic [7:0]  w_raw;
    logic [7:0]  w_scaled;
    logic        w_unused_div;

    // Only the step field of the divider matters; the low byte is sub-step resolution.
    assign w_unused_div = ^divider[7:0];
    assign w_step_len   = (r_div_lat == 10'd0) ? 10'd1 : r_div_lat;
    assign w_step_end   = (r_tick == w_step_len - 10'd1);

    always_comb begin
        w_raw = 8'd0;
        case (mode)
            2'b00:   w_raw = r_phase[7] ? 8'd0 : 8'd255;
            2'b01:   w_raw = r_phase;
            2'b10:   w_raw = r_phase[7] ? ~{r_phase[6:0], 1'b0} : {r_phase[6:0], 1'b0};
            default: w_raw = (r_phase[7:6] == 2'b00) ? 8'd255 : 8'd0;
        endcase
    end

`ifdef ENVELOPE_EN
    logic [31:0] r_env_cnt;
    logic [3:0]  r_vol;
    logic [11:0] w_prod;

    // Release keeps the oscillator running until the volume has decayed to zero.
    assign w_gate   = strobe | (r_vol != 4'd0);
    assign w_prod   = {4'd0, w_raw} * {8'd0, r_vol};
    assign w_scaled = w_prod[11:4];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_env_cnt <= 32'd0;
            r_vol     <= 4'd0;
        end else if (r_env_cnt == 32'(ENV_CYCLES - 1)) begin
            r_env_cnt <= 32'd0;
            if (strobe && r_vol != 4'd15)
                r_vol <= r_vol + 4'd1;
            else if (!strobe && r_vol != 4'd0)
                r_vol <= r_vol - 4'd1;
        end else begin
            r_env_cnt <= r_env_cnt + 32'd1;
        end
    end
`else
    assign w_gate   = strobe;
    assign w_scaled = w_raw;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_div_lat <= 10'd0;
            r_tick    <= 10'd0;
            r_phase   <= 8'd0;
            r_pwm_cnt <= 8'd0;
            sample    <= 8'd0;
            pwm_out   <= 1'b0;
            active    <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            pwm_out   <= (r_pwm_cnt < sample);
            sample    <= (r_state == PLAY) ? w_scaled : 8'd0;
            case (r_state)
                IDLE: begin
                    if (w_gate) begin
                        r_state   <= PLAY;
                        active    <= 1'b1;
                        r_div_lat <= divider[17:8];
                    end
                end
                default: begin
                    if (!w_gate) begin
                        r_state <= IDLE;
                        active  <= 1'b0;
                        r_tick  <= 10'd0;
                        r_phase <= 8'd0;
                    end else if (w_step_end) begin
                        r_tick  <= 10'd0;
                        r_phase <= r_phase + 8'd1;
                        // A new divider only takes hold at the period boundary.
                        if (r_phase == 8'hFF)
                            r_div_lat <= divider[17:8];
                    end else begin
                        r_tick <= r_tick + 10'd1;
                    end
                end
            endcase
        end
    end

endmodule
